// File: rtl/mips_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, IM geometry
// and the word_count legality rule.
package mips_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    localparam int IM_WORDS       = 32;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic wc_legal(input int unsigned wc, input int unsigned depth);
        return (wc != 0) && (wc <= depth);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host-side bundle of the loader: byte stream in, IM write port and status out.
// Stream handshake: a byte moves on a rising edge where byte_valid && byte_ready;
// byte_valid may drop at any time and byte_ready is a registered loader output.
interface imem_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, word_count, byte_valid, byte_data,
        input  byte_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  start, word_count, byte_valid, byte_data,
        output byte_ready, im_we, im_addr, im_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Packs stream bytes MSB-first into a word; word_valid_o fires combinationally on
// the byte that completes the word, with word_o already holding the full word.
module byte_assembler
    import mips_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    assign word_o       = {shreg_q[DATA_W-9:0], byte_i};
    assign word_valid_o = shift_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        if (clear_i) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (shift_en_i) begin
            cnt_d   = cnt_q + 2'd1;
            shreg_d = word_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream, verifies an XOR
// checksum and holds the CPU in reset while the load is running.
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output loader_state_t state_o
);
    loader_state_t     state_q;
    logic              ready_q, busy_q, cpu_reset_q, done_q, err_q, we_q;
    logic [ADDR_W-1:0] addr_q, idx_q, last_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        csum_q;

    logic              xfer, load_xfer, start_ok, word_valid;
    logic [DATA_W-1:0] word;

    assign xfer      = bus.byte_valid && ready_q;
    assign load_xfer = xfer && (state_q == ST_LOAD);
    assign start_ok  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    byte_assembler #(.DATA_W(DATA_W)) u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_ok),
        .shift_en_i   (load_xfer),
        .byte_i       (bus.byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            csum_q      <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    cpu_reset_q <= 1'b0;
                    if (start_ok) begin
                        if (wc_legal(32'(bus.word_count), 32'(1) << ADDR_W)) begin
                            state_q     <= ST_LOAD;
                            ready_q     <= 1'b1;
                            busy_q      <= 1'b1;
                            cpu_reset_q <= 1'b1;
                            done_q      <= 1'b0;
                            err_q       <= 1'b0;
                            idx_q       <= '0;
                            // word_count=32 has zero low bits, so this yields 31.
                            last_q      <= bus.word_count[ADDR_W-1:0] - ADDR_W'(1);
                            csum_q      <= '0;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_xfer) begin
                        csum_q <= csum_q ^ bus.byte_data;
                    end
                    if (word_valid) begin
                        we_q    <= 1'b1;
                        addr_q  <= idx_q;
                        wdata_q <= word;
                        if (idx_q == last_q) begin
                            state_q <= ST_CHECK;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        state_q     <= ST_DONE;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        cpu_reset_q <= 1'b0;
                        done_q      <= 1'b1;
                        err_q       <= (bus.byte_data != csum_q);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.im_we      = we_q;
    assign bus.im_addr    = addr_q;
    assign bus.im_wdata   = wdata_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader: reset state, checksum good/bad,
// illegal word counts, reset mid-load and a full 32-word program.
module tb_imem_loader;
    import mips_loader_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int ENT_W  = ADDR_W + DATA_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    loader_state_t state;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;

    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] obs_q[$];
    logic [31:0]      ld_words[$];

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            obs_q.push_back({bus.im_addr, bus.im_wdata});
            we_count++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: all input changes happen on the falling edge
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int n;
        bus.byte_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept_bound", 64'(n < 50), 64'(1));
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input int wc, input bit with_valid);
        bus.start      = 1'b1;
        bus.word_count = (ADDR_W+1)'(wc);
        if (with_valid) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'hA5;
        end
        @(negedge clk);
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_bound", 64'(n < 200), 64'(1));
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_addr"}, 64'(obs_q[i][ENT_W-1:DATA_W]), 64'(exp_q[i][ENT_W-1:DATA_W]));
            check({tag, "_data"}, 64'(obs_q[i][DATA_W-1:0]), 64'(exp_q[i][DATA_W-1:0]));
        end
    endtask

    // Reference model: word i lands at address i, bytes go out MSB first, checksum is
    // the XOR of every data byte; a corrupted checksum byte must raise err.
    task automatic run_load(input string tag, input bit bad_cs, input int max_gap,
                            input bit coincide, input bit poke_start);
        logic [7:0] cs;
        int         nb;
        exp_q.delete();
        obs_q.delete();
        cs = 8'h00;
        for (int i = 0; i < ld_words.size(); i++) begin
            exp_q.push_back({ADDR_W'(i), ld_words[i]});
            for (int k = 3; k >= 0; k--) cs = cs ^ ld_words[i][8*k +: 8];
        end
        if (bad_cs) cs = cs ^ 8'h01;

        pulse_start(ld_words.size(), coincide);
        check({tag, "_state_load"}, 64'(state), 64'(ST_LOAD));
        check({tag, "_start_cpu_reset"}, 64'(bus.cpu_reset), 64'(1));
        check({tag, "_start_done_clr"}, 64'({bus.done, bus.err}), 64'(0));
        check({tag, "_start_ready"}, 64'({bus.busy, bus.byte_ready}), 64'(2'b11));

        nb = 0;
        for (int i = 0; i < ld_words.size(); i++) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(ld_words[i][8*k +: 8], max_gap);
                nb++;
                if (poke_start && nb == 2) begin
                    pulse_start(0, 1'b0);
                    check({tag, "_start_ignored"}, 64'({bus.busy, bus.done}), 64'(2'b10));
                end
            end
        end
        check({tag, "_check_state"}, 64'(state), 64'(ST_CHECK));
        check({tag, "_check_cpu_reset"}, 64'({bus.cpu_reset, bus.byte_ready}), 64'(2'b11));

        send_byte(cs, max_gap);
        wait_done();
        check({tag, "_done"}, 64'(bus.done), 64'(1));
        check({tag, "_err"}, 64'(bus.err), 64'(bad_cs));
        check({tag, "_done_outputs"},
              64'({bus.cpu_reset, bus.byte_ready, bus.busy, bus.im_we}), 64'(0));
        compare_writes(tag);
        repeat (3) @(negedge clk);
        check({tag, "_done_sticky"}, 64'({bus.done, bus.err}), 64'({1'b1, bad_cs}));
    endtask

    initial begin
        int we_before;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;

        // 1. reset values
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 64'(bus.cpu_reset), 64'(1));
        check("rst_outputs", 64'({bus.byte_ready, bus.im_we, bus.busy, bus.done, bus.err}), 64'(0));
        check("rst_addr_data", 64'({bus.im_addr, bus.im_wdata}), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cpu_reset", 64'(bus.cpu_reset), 64'(0));
        check("post_rst_ready", 64'(bus.byte_ready), 64'(0));
        check("post_rst_state", 64'(state), 64'(ST_IDLE));

        // 2. two words, good checksum; a byte offered with start must not be taken
        ld_words = '{32'h12345678, 32'h9ABCDEF0};
        run_load("two_good", 1'b0, 0, 1'b1, 1'b0);

        // 3. same stream, bad checksum; start during the load is ignored
        run_load("two_bad", 1'b1, 0, 1'b0, 1'b1);

        // 4. illegal word counts, with the stream trying to push bytes
        foreach (ld_words[i]) ld_words[i] = 32'h0;
        we_before = we_count;
        pulse_start(0, 1'b1);
        check("wc0_done_err", 64'({bus.done, bus.err}), 64'(2'b11));
        check("wc0_ready", 64'(bus.byte_ready), 64'(0));
        pulse_start(33, 1'b1);
        check("wc33_done_err", 64'({bus.done, bus.err}), 64'(2'b11));
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.byte_valid = 1'b0;
        check("wc33_ready", 64'({bus.byte_ready, bus.busy, bus.cpu_reset}), 64'(0));
        check("illegal_no_we", 64'(we_count), 64'(we_before));

        // 5. reset after the 3rd byte of a single-word load
        ld_words = '{$urandom()};
        obs_q.delete();
        we_before = we_count;
        pulse_start(1, 1'b0);
        for (int k = 3; k >= 1; k--) send_byte(ld_words[0][8*k +: 8], 3);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_state", 64'(state), 64'(ST_IDLE));
        check("midrst_cpu_reset", 64'(bus.cpu_reset), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("midrst_idle_outputs",
              64'({bus.cpu_reset, bus.byte_ready, bus.busy, bus.done, bus.err}), 64'(0));
        repeat (2) @(negedge clk);
        check("midrst_no_we", 64'(we_count), 64'(we_before));
        ld_words = '{$urandom()};
        run_load("after_rst", 1'b0, 3, 1'b0, 1'b0);

        // randomized loads with gaps and random checksum corruption
        for (int r = 0; r < 4; r++) begin
            int wc;
            wc = $urandom_range(1, 8);
            ld_words.delete();
            for (int i = 0; i < wc; i++) ld_words.push_back($urandom());
            run_load("rand", 1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)), 1'b0);
        end

        // 6. full-depth program, no address wrap
        ld_words.delete();
        for (int i = 0; i < IM_WORDS; i++) ld_words.push_back($urandom());
        run_load("full32", 1'b0, 0, 1'b0, 1'b0);
        check("full32_last_addr", 64'(obs_q[obs_q.size()-1][ENT_W-1:DATA_W]), 64'(IM_WORDS - 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
